// File: rtl/easyaxi_pkg.sv
// Shared constants for the easyaxi read path: entry state encodings and
// fixed AXI burst attributes.
package easyaxi_pkg;

    localparam logic [1:0] ST_FREE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_OUTS = 2'd2;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    function automatic logic [2:0] axi_size(input int bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/easyaxi_rd_buf.sv
// Read-request buffer: tracks DEEP_NUM AXI read IDs, issues AR through a
// one-deep slot, frees on R-last. Optional checker: EASYAXI_RD_BUF_ERR_CHK_EN.
//
// state | meaning
// FREE  | entry unused, may be allocated
// PEND  | request captured, waiting for the arbiter to pick it
// OUTS  | AR loaded into slot / issued, waiting for R-last
module easyaxi_rd_buf
    import easyaxi_pkg::*;
#(
    parameter int DEEP_NUM   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    input  logic [7:0]                  req_len,

    output logic                        axi_arvalid,
    input  logic                        axi_arready,
    output logic [ADDR_WIDTH-1:0]       axi_araddr,
    output logic [7:0]                  axi_arlen,
    output logic [$clog2(DEEP_NUM)-1:0] axi_arid,
    output logic [2:0]                  axi_arsize,
    output logic [1:0]                  axi_arburst,

    input  logic                        axi_rvalid,
    input  logic                        axi_rready,
    input  logic [$clog2(DEEP_NUM)-1:0] axi_rid,
    input  logic                        axi_rlast,

    output logic [DEEP_NUM-1:0]         sche_pend,
    input  logic [$clog2(DEEP_NUM)-1:0] sche_ptr,
    output logic                        sche_en,

    output logic [$clog2(DEEP_NUM):0]   outs_cnt,
    output logic                        err
);

    localparam int ID_W = $clog2(DEEP_NUM);
    localparam logic [2:0] AR_SIZE = axi_size(DATA_BYTES);

    logic [1:0]            r_state [DEEP_NUM];
    logic [ADDR_WIDTH-1:0] r_addr  [DEEP_NUM];
    logic [7:0]            r_len   [DEEP_NUM];

    logic                  r_ar_valid;
    logic [ADDR_WIDTH-1:0] r_ar_addr;
    logic [7:0]            r_ar_len;
    logic [ID_W-1:0]       r_ar_id;

    logic [DEEP_NUM-1:0]   w_free_vec;
    logic [DEEP_NUM-1:0]   w_pend_vec;
    logic [ID_W:0]         w_cnt;
    logic [ID_W-1:0]       w_alloc_idx;
    logic                  w_alloc;
    logic                  w_rlast;
    logic                  w_free_hit;
    logic                  w_load;

    always_comb begin
        w_free_vec = '0;
        w_pend_vec = '0;
        w_cnt      = '0;
        for (int i = 0; i < DEEP_NUM; i++) begin
            w_free_vec[i] = (r_state[i] == ST_FREE);
            w_pend_vec[i] = (r_state[i] == ST_PEND);
            if (r_state[i] != ST_FREE)
                w_cnt = w_cnt + {{ID_W{1'b0}}, 1'b1};
        end
    end

    // Descending scan leaves the lowest FREE index as the winner.
    always_comb begin
        w_alloc_idx = '0;
        for (int i = DEEP_NUM - 1; i >= 0; i--) begin
            if (w_free_vec[i])
                w_alloc_idx = ID_W'(i);
        end
    end

    assign req_ready  = |w_free_vec;
    assign w_alloc    = req_valid & req_ready;
    assign w_rlast    = axi_rvalid & axi_rready & axi_rlast;
    assign w_free_hit = w_rlast && (r_state[axi_rid] == ST_OUTS);
    assign w_load     = (|w_pend_vec) && w_pend_vec[sche_ptr] &&
                        (!r_ar_valid || axi_arready);

    // Slot entries are already OUTS, so the PEND vector never includes them.
    assign sche_pend = w_pend_vec;
    assign sche_en   = w_load;
    assign outs_cnt  = w_cnt;

    // Alloc, load and free each act on a distinct source state, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEEP_NUM; i++)
                r_state[i] <= ST_FREE;
        end else begin
            for (int i = 0; i < DEEP_NUM; i++) begin
                if (w_alloc && (w_alloc_idx == ID_W'(i)))
                    r_state[i] <= ST_PEND;
                else if (w_load && (sche_ptr == ID_W'(i)))
                    r_state[i] <= ST_OUTS;
                else if (w_free_hit && (axi_rid == ID_W'(i)))
                    r_state[i] <= ST_FREE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[w_alloc_idx] <= req_addr;
            r_len[w_alloc_idx]  <= req_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ar_valid <= 1'b0;
        else if (w_load)
            r_ar_valid <= 1'b1;
        else if (axi_arready)
            r_ar_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_ar_addr <= r_addr[sche_ptr];
            r_ar_len  <= r_len[sche_ptr];
            r_ar_id   <= sche_ptr;
        end
    end

    assign axi_arvalid = r_ar_valid;
    assign axi_araddr  = r_ar_addr;
    assign axi_arlen   = r_ar_len;
    assign axi_arid    = r_ar_id;
    assign axi_arsize  = AR_SIZE;
    assign axi_arburst = AXI_BURST_INCR;

`ifdef EASYAXI_RD_BUF_ERR_CHK_EN
    logic r_err;
    logic w_ptr_bad;

    assign w_ptr_bad = (|w_pend_vec) && !w_pend_vec[sche_ptr];

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if ((w_rlast && !w_free_hit) || w_ptr_bad)
            r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
